// File: rtl/cla8_sub_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : cla8_sub_pipe_if
// Purpose  : Streaming bus for the 8-bit pipelined CLA subtractor. It carries
//            the operand beat (valid/ready, a, b, bin) and the result beat
//            (valid/ready, diff, bout, ovf).
// Modports : slave  - the subtractor: consumes operands, produces results
//            master - the producer/consumer surrounding the subtractor
// Revision : 1.0 - initial release
// ============================================================================
interface cla8_sub_pipe_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/cla8_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cla8_sub_pipe
// Purpose  : 8-bit two-stage pipelined subtractor, diff = a - b - bin, built
//            on carry-lookahead terms. Stage 1 resolves the low nibble and
//            the nibble carry; stage 2 resolves the high nibble, borrow-out
//            and signed overflow. Sustains one beat per cycle under full
//            valid/ready backpressure.
// Ports    : clk    - rising-edge clock
//            rst    - synchronous active-high reset
//            io_bus - cla8_sub_pipe_if.slave (operand and result streams)
// Options  : CLA8_SUB_SAT_EN - when defined, diff saturates to 8'h00 whenever
//            the subtraction borrows; bout/ovf still report the raw result.
// Revision : 1.0 - initial release
// ============================================================================
module cla8_sub_pipe (
  input  wire              clk,
  input  wire              rst,
  cla8_sub_pipe_if.slave   io_bus
);

  // Lookahead carries for one nibble; bit 0 is the carry in, bit 4 the
  // carry out.
  function automatic logic [4:0] f_cla4(input logic [3:0] p,
                                        input logic [3:0] g,
                                        input logic       c0);
    logic [4:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // --------------------------------------------------------------------------
  // Handshake: a stage advances when it is empty or its downstream advances.
  // --------------------------------------------------------------------------
  logic w_s1_adv;
  logic w_s2_adv;

  logic       r_s1_valid;
  logic [3:0] r_s1_diff_lo;
  logic       r_s1_c4;
  logic [3:0] r_s1_p_hi;
  logic [3:0] r_s1_g_hi;
  logic       r_s1_a7;
  logic       r_s1_b7;

  logic       r_s2_valid;
  logic [7:0] r_s2_diff;
  logic       r_s2_bout;
  logic       r_s2_ovf;

  assign w_s2_adv = !r_s2_valid || io_bus.out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;

  // --------------------------------------------------------------------------
  // Stage 1: a - b - bin is computed as a + ~b + ~bin.
  // --------------------------------------------------------------------------
  logic [7:0] w_p;
  logic [7:0] w_g;
  logic [4:0] w_c_lo;
  logic [3:0] w_diff_lo;

  assign w_p       = io_bus.a ^ ~io_bus.b;
  assign w_g       = io_bus.a & ~io_bus.b;
  assign w_c_lo    = f_cla4(w_p[3:0], w_g[3:0], ~io_bus.bin);
  assign w_diff_lo = w_p[3:0] ^ w_c_lo[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_diff_lo <= 4'h0;
      r_s1_c4      <= 1'b0;
      r_s1_p_hi    <= 4'h0;
      r_s1_g_hi    <= 4'h0;
      r_s1_a7      <= 1'b0;
      r_s1_b7      <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid   <= io_bus.in_valid;
      r_s1_diff_lo <= w_diff_lo;
      r_s1_c4      <= w_c_lo[4];
      r_s1_p_hi    <= w_p[7:4];
      r_s1_g_hi    <= w_g[7:4];
      r_s1_a7      <= io_bus.a[7];
      r_s1_b7      <= io_bus.b[7];
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: high nibble from the registered nibble carry. The final carry
  // is the inverse of the borrow.
  // --------------------------------------------------------------------------
  logic [4:0] w_c_hi;
  logic [7:0] w_s2_raw;
  logic       w_s2_bout;
  logic       w_s2_ovf;
  logic [7:0] w_s2_diff;

  assign w_c_hi    = f_cla4(r_s1_p_hi, r_s1_g_hi, r_s1_c4);
  assign w_s2_raw  = {r_s1_p_hi ^ w_c_hi[3:0], r_s1_diff_lo};
  assign w_s2_bout = ~w_c_hi[4];
  assign w_s2_ovf  = (r_s1_a7 != r_s1_b7) && (w_s2_raw[7] != r_s1_a7);

`ifdef CLA8_SUB_SAT_EN
  assign w_s2_diff = w_s2_bout ? 8'h00 : w_s2_raw;
`else
  assign w_s2_diff = w_s2_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_diff  <= 8'h00;
      r_s2_bout  <= 1'b0;
      r_s2_ovf   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_diff  <= w_s2_diff;
      r_s2_bout  <= w_s2_bout;
      r_s2_ovf   <= w_s2_ovf;
    end
  end

  assign io_bus.in_ready  = w_s1_adv;
  assign io_bus.out_valid = r_s2_valid;
  assign io_bus.diff      = r_s2_diff;
  assign io_bus.bout      = r_s2_bout;
  assign io_bus.ovf       = r_s2_ovf;

endmodule
`default_nettype wire
